// File: rtl/prefix_pipe_pkg.sv
// Shared constants and types for the pipelined Kogge-Stone adder.
package prefix_pipe_pkg;

  // Operand width; must be a power of two. Prefix depth is log2(WIDTH).
  localparam int WIDTH  = 32;
  localparam int LEVELS = 5;

  // Prefix levels resolved in stage 2 (spans 1, 2, 4); the rest go in stage 3.
  localparam int S2_LEVELS = 3;

  // Generate/propagate pair carried through the prefix tree.
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

endpackage

// File: rtl/prefix_cell.sv
// Kogge-Stone black cell: combines a higher-order (g,p) pair with a
// lower-order one. Used as a gray cell when p_out is left unused.
module prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;

endmodule

// File: rtl/prefix_pipe.sv
// 32-bit three-stage pipelined Kogge-Stone adder: {cout, y} = a + b + c0.
// Stage 1 forms bitwise p/g (carry-in folded into bit 0), stage 2 resolves
// prefix spans 1/2/4, stage 3 resolves spans 8/16 and forms the sum.
module prefix_pipe
  import prefix_pipe_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  input  logic             clk,
  input  logic             rst
);

  // ---------------- stage 1: bitwise terms ----------------
  logic [WIDTH-1:0] p_in, g_in;
  logic [WIDTH-1:0] p_s1, g_s1;
  logic             c0_s1;

  assign p_in = a ^ b;
  // Folding c0 into bit 0 makes G[i:0] the carry into bit i+1 directly.
  assign g_in = (a & b) | {{(WIDTH-1){1'b0}}, p_in[0] & c0};

  // Stage-1 register: bitwise propagate, folded generate and carry-in.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_s1  <= '0;
      g_s1  <= '0;
      c0_s1 <= 1'b0;
    end else begin
      p_s1  <= p_in;
      g_s1  <= g_in;
      c0_s1 <= c0;
    end
  end

  // ---------------- stage 2: prefix levels 1-3 ----------------
  logic [WIDTH-1:0] g_l1, p_l1, g_l2, p_l2, g_l3, p_l3;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lvl1
    if (i >= 1) begin : g_cell
      prefix_cell u_cell (.g_hi(g_s1[i]), .p_hi(p_s1[i]), .g_lo(g_s1[i-1]), .p_lo(p_s1[i-1]),
                          .g_out(g_l1[i]), .p_out(p_l1[i]));
    end else begin : g_pass
      assign g_l1[i] = g_s1[i];
      assign p_l1[i] = p_s1[i];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lvl2
    if (i >= 2) begin : g_cell
      prefix_cell u_cell (.g_hi(g_l1[i]), .p_hi(p_l1[i]), .g_lo(g_l1[i-2]), .p_lo(p_l1[i-2]),
                          .g_out(g_l2[i]), .p_out(p_l2[i]));
    end else begin : g_pass
      assign g_l2[i] = g_l1[i];
      assign p_l2[i] = p_l1[i];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lvl3
    if (i >= 4) begin : g_cell
      prefix_cell u_cell (.g_hi(g_l2[i]), .p_hi(p_l2[i]), .g_lo(g_l2[i-4]), .p_lo(p_l2[i-4]),
                          .g_out(g_l3[i]), .p_out(p_l3[i]));
    end else begin : g_pass
      assign g_l3[i] = g_l2[i];
      assign p_l3[i] = p_l2[i];
    end
  end

  logic [WIDTH-1:0] gg_s2, gp_s2, p_s2;
  logic             c0_s2;

  // Stage-2 register: partial group G/P plus the bitwise p and c0 needed for the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      gg_s2 <= '0;
      gp_s2 <= '0;
      p_s2  <= '0;
      c0_s2 <= 1'b0;
    end else begin
      gg_s2 <= g_l3;
      gp_s2 <= p_l3;
      p_s2  <= p_s1;
      c0_s2 <= c0_s1;
    end
  end

  // ---------------- stage 3: prefix levels 4-5 and sum ----------------
  logic [WIDTH-1:0] g_l4, p_l4, g_l5, p_l5;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lvl4
    if (i >= 8) begin : g_cell
      prefix_cell u_cell (.g_hi(gg_s2[i]), .p_hi(gp_s2[i]), .g_lo(gg_s2[i-8]), .p_lo(gp_s2[i-8]),
                          .g_out(g_l4[i]), .p_out(p_l4[i]));
    end else begin : g_pass
      assign g_l4[i] = gg_s2[i];
      assign p_l4[i] = gp_s2[i];
    end
  end

  // Last level only needs group generate; p_l5 is left unused (gray cells).
  for (genvar i = 0; i < WIDTH; i++) begin : g_lvl5
    if (i >= 16) begin : g_cell
      prefix_cell u_cell (.g_hi(g_l4[i]), .p_hi(p_l4[i]), .g_lo(g_l4[i-16]), .p_lo(p_l4[i-16]),
                          .g_out(g_l5[i]), .p_out(p_l5[i]));
    end else begin : g_pass
      assign g_l5[i] = g_l4[i];
      assign p_l5[i] = p_l4[i];
    end
  end

  logic unused_p_l5;
  assign unused_p_l5 = ^p_l5;

  // Carry into bit i is G[i-1:0]; bit 0 takes the raw carry-in.
  logic [WIDTH-1:0] carry;
  assign carry = {g_l5[WIDTH-2:0], c0_s2};

  // Stage-3 register: the only source of the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      y    <= '0;
      cout <= 1'b0;
    end else begin
      y    <= p_s2 ^ carry;
      cout <= g_l5[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_prefix_pipe.sv
// Self-checking bench for prefix_pipe: directed and random operand sets
// compared against a plain-arithmetic sum delayed through a 3-deep line.
module tb_prefix_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, y;
  logic        c0, cout;

  logic [32:0] m1, m2, m3;
  int          checks = 0;
  int          passed = 0;

  prefix_pipe dut (
    .a   (a),
    .b   (b),
    .c0  (c0),
    .y   (y),
    .cout(cout),
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [31:0] ai, input logic [31:0] bi, input logic ci,
                      input logic ri, input string tag);
    a   = ai;
    b   = bi;
    c0  = ci;
    rst = ri;
    @(posedge clk);
    if (ri) begin
      m1 = '0;
      m2 = '0;
      m3 = '0;
    end else begin
      m3 = m2;
      m2 = m1;
      m1 = 33'(ai) + 33'(bi) + 33'(ci);
    end
    #1;
    checks++;
    assert ({cout, y} === m3) passed++;
    else $error("FAIL %s: observed cout=%0b y=%08h, expected cout=%0b y=%08h",
                tag, cout, y, m3[32], m3[31:0]);
  endtask

  initial begin
    // Reset held for two edges with arbitrary inputs.
    step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, "reset");
    step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, "reset");

    // Directed vectors back to back, then boundaries.
    step(32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, "complement");
    step(32'h0000FFFF, 32'hFFFF0000, 1'b1, 1'b0, "full_ripple");
    step(32'h00000007, 32'h00000003, 1'b0, 1'b0, "small_add");
    step(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, "wrap_by_cin");
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, "all_ones");
    step(32'h80000000, 32'h80000000, 1'b0, 1'b0, "msb_carry");

    // Random operands, with some forced to all-ones/zero/complement patterns.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case (i % 6)
        1: rb = ~ra;
        3: ra = 32'hFFFFFFFF;
        5: rb = 32'h00000000;
        default: ;
      endcase
      step(ra, rb, 1'($urandom_range(0, 1)), 1'b0, "random");
    end

    // Reset mid-stream discards in-flight results.
    step($urandom, $urandom, 1'b1, 1'b0, "pre_reset");
    step($urandom, $urandom, 1'b0, 1'b0, "pre_reset");
    step($urandom, $urandom, 1'b1, 1'b1, "mid_reset");
    for (int i = 0; i < 5; i++)
      step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, "post_reset");

    // Drain the pipeline.
    for (int i = 0; i < 3; i++)
      step(32'h0, 32'h0, 1'b0, 1'b0, "flush");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
